// File: rtl/alu_seq.sv
// Execute sequencer for the external 8-bit alu.
// Register file, C/Z flags and a two-pass carry chain for wide pair ops.
module alu_seq #(
  parameter  int NREG = 4,
  localparam int RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [RW-1:0] cmd_rd,
  input  logic [RW-1:0] cmd_rs,
  input  logic          cmd_wide,
  input  logic          cmd_usec,
  input  logic          load_en,
  input  logic [RW-1:0] load_addr,
  input  logic [7:0]    load_data,
  input  logic [RW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic          alu_cin,
  output logic [2:0]    alu_op,
  input  logic [7:0]    alu_y,
  input  logic          alu_cout,
  output logic          done_valid,
  output logic [7:0]    done_y,
  output logic          flag_c,
  output logic          flag_z
);

  typedef enum logic [1:0] {IDLE, EX0, EX1, DONE} state_e;

  localparam logic [2:0]    OP_RRC = 3'b011;
  localparam logic [RW-1:0] ONE    = 1;

  state_e        state_q, state_d;
  logic [7:0]    regs_q [NREG];
  logic [7:0]    regs_d [NREG];
  logic [2:0]    op_q, op_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [RW-1:0] rs_q, rs_d;
  logic          wide_q, wide_d;
  logic          usec_q, usec_d;
  logic          chain_q, chain_d;
  logic          zacc_q, zacc_d;
  logic          c_q, c_d;
  logic          z_q, z_d;
  logic [7:0]    done_y_q, done_y_d;

  logic          ex;
  logic          pass_hi;
  logic          last;
  logic [RW-1:0] a_idx;
  logic [RW-1:0] b_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cmd_valid) state_d = EX0;
      EX0:  state_d = wide_q ? EX1 : DONE;
      EX1:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = (state_q == IDLE);
    done_valid = (state_q == DONE);
    ex         = (state_q == EX0) || (state_q == EX1);
  end

  // RRC rotates right, so the high byte must go first to feed its lsb down.
  always_comb begin
    pass_hi = (op_q == OP_RRC);
    if (state_q == EX1) pass_hi = ~pass_hi;
    a_idx = rd_q;
    b_idx = rs_q;
    if (wide_q) begin
      a_idx = (rd_q & ~ONE) | (pass_hi ? ONE : '0);
      b_idx = (rs_q & ~ONE) | (pass_hi ? ONE : '0);
    end
    last = (state_q == EX1) || !wide_q;
  end

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    alu_op  = '0;
    if (ex) begin
      alu_a   = regs_q[a_idx];
      alu_b   = regs_q[b_idx];
      alu_op  = op_q;
      alu_cin = (state_q == EX0) ? (usec_q & c_q) : chain_q;
    end
  end

  always_comb begin
    regs_d   = regs_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rs_d     = rs_q;
    wide_d   = wide_q;
    usec_d   = usec_q;
    chain_d  = chain_q;
    zacc_d   = zacc_q;
    c_d      = c_q;
    z_d      = z_q;
    done_y_d = done_y_q;
    if (state_q == IDLE) begin
      if (load_en) regs_d[load_addr] = load_data;
      if (cmd_valid) begin
        op_d   = cmd_op;
        rd_d   = cmd_rd;
        rs_d   = cmd_rs;
        wide_d = cmd_wide;
        usec_d = cmd_usec;
      end
    end else if (ex) begin
      regs_d[a_idx] = alu_y;
      chain_d       = alu_cout;
      zacc_d        = (alu_y == 8'h00);
      if (last) begin
        c_d      = alu_cout;
        z_d      = (alu_y == 8'h00) && (state_q == EX0 || zacc_q);
        done_y_d = alu_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      wide_q   <= 1'b0;
      usec_q   <= 1'b0;
      chain_q  <= 1'b0;
      zacc_q   <= 1'b0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      done_y_q <= '0;
    end else begin
      regs_q   <= regs_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs_q     <= rs_d;
      wide_q   <= wide_d;
      usec_q   <= usec_d;
      chain_q  <= chain_d;
      zacc_q   <= zacc_d;
      c_q      <= c_d;
      z_q      <= z_d;
      done_y_q <= done_y_d;
    end
  end

  assign rd_data = regs_q[rd_addr];
  assign done_y  = done_y_q;
  assign flag_c  = c_q;
  assign flag_z  = z_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural alu and a result scoreboard.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [1:0] cmd_rd = '0;
  logic [1:0] cmd_rs = '0;
  logic       cmd_wide = 1'b0;
  logic       cmd_usec = 1'b0;
  logic       load_en = 1'b0;
  logic [1:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic [1:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic [7:0] alu_a, alu_b, alu_y;
  logic       alu_cin, alu_cout;
  logic [2:0] alu_op;
  logic       done_valid;
  logic [7:0] done_y;
  logic       flag_c, flag_z;

  typedef struct {
    logic [7:0] y;
    logic       c;
    logic       z;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;
  logic [7:0] ex0_a;
  logic       ex0_cin, ex1_cin;

  always #5 clk = ~clk;

  alu_seq #(.NREG(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs),
    .cmd_wide(cmd_wide), .cmd_usec(cmd_usec),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_y(alu_y), .alu_cout(alu_cout),
    .done_valid(done_valid), .done_y(done_y),
    .flag_c(flag_c), .flag_z(flag_z)
  );

  // Behavioural alu: ops AND OR COMP RRC RLC ADD SUB MOVE.
  always_comb begin
    logic [8:0] t;
    t = '0;
    unique case (alu_op)
      3'b000: t = {1'b0, alu_a & alu_b};
      3'b001: t = {1'b0, alu_a | alu_b};
      3'b010: t = {1'b0, ~alu_a};
      3'b011: t = {alu_a[0], alu_cin, alu_a[7:1]};
      3'b100: t = {alu_a[7], alu_a[6:0], alu_cin};
      3'b101: t = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
      3'b110: t = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_cin};
      default: t = {1'b0, alu_b};
    endcase
    alu_y    = t[7:0];
    alu_cout = t[8];
  end

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic reg_chk(input string tag, input logic [1:0] a,
                         input logic [7:0] exp);
    rd_addr = a;
    #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic push(input logic [7:0] y, input logic c, input logic z);
    exp_t e;
    e.y = y;
    e.c = c;
    e.z = z;
    q.push_back(e);
  endtask

  // Returns at the negedge of cycle N+1; cmd_valid is left asserted.
  task automatic send(input logic [2:0] op, input logic [1:0] rd,
                      input logic [1:0] rs, input logic w, input logic u);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs    = rs;
    cmd_wide  = w;
    cmd_usec  = u;
    n = 0;
    while (!cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {7'd0, cmd_ready}, 8'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int   lat;
    exp_t e;
    lat     = 1;
    ex0_a   = alu_a;
    ex0_cin = alu_cin;
    ex1_cin = 1'b0;
    while (!done_valid && lat < 8) begin
      @(negedge clk);
      lat++;
      if (lat == 2) ex1_cin = alu_cin;
    end
    chk({tag, "_lat"}, 8'(lat), 8'(exp_lat));
    chk({tag, "_sb"}, 8'(q.size() > 0), 8'd1);
    e.y = 8'hxx;
    e.c = 1'bx;
    e.z = 1'bx;
    if (q.size() > 0) e = q.pop_front();
    chk({tag, "_y"}, done_y, e.y);
    chk({tag, "_c"}, {7'd0, flag_c}, {7'd0, e.c});
    chk({tag, "_z"}, {7'd0, flag_z}, {7'd0, e.z});
  endtask

  initial begin
    int seen;
    @(negedge clk);
    chk("rst_ready", {7'd0, cmd_ready}, 8'd1);
    chk("rst_done", {7'd0, done_valid}, 8'd0);
    chk("rst_y", done_y, 8'h00);
    chk("rst_c", {7'd0, flag_c}, 8'd0);
    chk("rst_z", {7'd0, flag_z}, 8'd0);
    chk("rst_alu", {alu_a | alu_b}, 8'h00);
    chk("rst_aluctl", {4'd0, alu_op, alu_cin}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) reg_chk("rst_reg", 2'(i), 8'h00);

    // narrow ADD
    load(0, 8'h14);
    load(1, 8'h27);
    push(8'h3B, 1'b0, 1'b0);
    send(3'b101, 0, 1, 1'b0, 1'b0);
    cmd_valid = 1'b0;
    wait_done("nadd", 2);
    reg_chk("nadd_r0", 0, 8'h3B);
    reg_chk("nadd_r1", 1, 8'h27);

    // wide ADD, carry chains into high byte
    load(0, 8'hFF);
    load(1, 8'h00);
    load(2, 8'h01);
    load(3, 8'h00);
    push(8'h01, 1'b0, 1'b0);
    send(3'b101, 0, 2, 1'b1, 1'b0);
    cmd_valid = 1'b0;
    wait_done("wadd", 3);
    chk("wadd_ex1cin", {7'd0, ex1_cin}, 8'd1);
    reg_chk("wadd_r0", 0, 8'h00);
    reg_chk("wadd_r1", 1, 8'h01);

    // wide SUB, borrow through
    load(0, 8'h00);
    load(1, 8'h00);
    push(8'hFF, 1'b1, 1'b0);
    send(3'b110, 0, 2, 1'b1, 1'b0);
    cmd_valid = 1'b0;
    wait_done("wsub", 3);
    reg_chk("wsub_r0", 0, 8'hFF);
    reg_chk("wsub_r1", 1, 8'hFF);

    // wide RRC using C=1, high byte first
    load(0, 8'h01);
    load(1, 8'h00);
    push(8'h00, 1'b1, 1'b0);
    send(3'b011, 0, 0, 1'b1, 1'b1);
    cmd_valid = 1'b0;
    wait_done("wrrc", 3);
    chk("wrrc_ex0a", ex0_a, 8'h00);
    chk("wrrc_ex0cin", {7'd0, ex0_cin}, 8'd1);
    reg_chk("wrrc_r0", 0, 8'h00);
    reg_chk("wrrc_r1", 1, 8'h80);

    // AND clears C, sets Z
    load(0, 8'hA5);
    load(1, 8'h5A);
    push(8'h00, 1'b0, 1'b1);
    send(3'b000, 0, 1, 1'b0, 1'b0);
    cmd_valid = 1'b0;
    wait_done("and", 2);
    reg_chk("and_r0", 0, 8'h00);
    reg_chk("and_r1", 1, 8'h5A);

    // busy: command and load held across a wide MOVE
    load(0, 8'h12);
    load(1, 8'h34);
    push(8'h34, 1'b0, 1'b0);
    send(3'b111, 2, 0, 1'b1, 1'b0);
    load_en   = 1'b1;
    load_addr = 0;
    load_data = 8'h56;
    wait_done("busy1", 3);
    chk("busy_ready", {7'd0, cmd_ready}, 8'd0);
    reg_chk("busy_r0", 0, 8'h12);
    reg_chk("busy_r2", 2, 8'h12);
    reg_chk("busy_r3", 3, 8'h34);
    push(8'h34, 1'b0, 1'b0);
    @(negedge clk);
    chk("idle_ready", {7'd0, cmd_ready}, 8'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    load_en   = 1'b0;
    wait_done("busy2", 3);
    reg_chk("busy2_r0", 0, 8'h56);
    reg_chk("busy2_r2", 2, 8'h56);
    reg_chk("busy2_r3", 3, 8'h34);

    // reset during EX1
    send(3'b101, 0, 2, 1'b1, 1'b0);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("ex1_ready", {7'd0, cmd_ready}, 8'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", {7'd0, cmd_ready}, 8'd1);
    chk("arst_done", {7'd0, done_valid}, 8'd0);
    chk("arst_alu", alu_a, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", {7'd0, cmd_ready}, 8'd1);
    chk("rel_c", {7'd0, flag_c}, 8'd0);
    chk("rel_z", {7'd0, flag_z}, 8'd0);
    chk("rel_y", done_y, 8'h00);
    for (int i = 0; i < 4; i++) reg_chk("rel_reg", 2'(i), 8'h00);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done_valid) seen++;
    end
    chk("rel_nodone", 8'(seen), 8'd0);
    chk("sb_empty", 8'(q.size()), 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Execute sequencer for the 8-bit combinational `alu` (ops AND, OR, COMP, RRC, RLC, ADD, SUB-with-borrow, MOVE).

- Accepts register-to-register commands over a valid/ready handshake.
- Holds a small register file plus carry and zero flags, drives the external `alu` instance, and writes results back.
- Chains two ALU passes through the carry for 16-bit ("wide") operations on register pairs.
- Sits between the instruction decode and the `alu` instance.

## Interface
- `NREG`, default 4: register-file depth. Power of two, ≥2; index width `RW=$clog2(NREG)`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 3: ALU opcode, passed unchanged to `alu_op`.
- `cmd_rd` in RW: destination register, also the `a` operand.
- `cmd_rs` in RW: source register, the `b` operand.
- `cmd_wide` in 1: 16-bit pair operation.
- `cmd_usec` in 1: first-pass cin = C flag (else 0).
- `load_en` in 1: direct register write.
- `load_addr` in RW: register to write.
- `load_data` in 8: data to write.
- `rd_addr` in RW: debug read address.
- `rd_data` out 8: combinational `reg[rd_addr]`.
- `alu_a` out 8: to `alu.a`.
- `alu_b` out 8: to `alu.b`.
- `alu_cin` out 1: to `alu.cin`.
- `alu_op` out 3: to `alu.op`.
- `alu_y` in 8: from `alu.y`.
- `alu_cout` in 1: from `alu.cout`.
- `done_valid` out 1: one-cycle completion pulse.
- `done_y` out 8: last byte written by the completed command.
- `flag_c` out 1: carry/borrow flag.
- `flag_z` out 1: zero flag.

## Operation
- States: IDLE, EX0, EX1, DONE.
- **IDLE:** `cmd_ready=1`. A handshake latches op/rd/rs/wide/usec and moves to EX0.
  - `load_en` writes only in IDLE; it is ignored in every other state.
  - A load in the handshake cycle is written, and the command sees the new value.
- **Wide register pairing:**
  - Pair base = index with LSB forced to 0; low byte = even register, high byte = odd register. The LSB of `cmd_rd`/`cmd_rs` is ignored.
  - Pass order: RRC processes the high byte first; all other ops process the low byte first.
- **EX0:**
  - Drives `alu_a=reg[rd byte0]`, `alu_b=reg[rs byte0]`, `alu_op=op`, `alu_cin = usec ? C : 0`.
  - At the clock edge, writes `alu_y` to the destination byte and captures `alu_cout` into an internal chain bit.
  - Narrow → DONE; wide → EX1.
- **EX1:**
  - Drives the second byte with `alu_cin` = chain bit.
  - Writes `alu_y` and goes to DONE.
- **DONE:** `done_valid=1` for one cycle, then IDLE.
- **Flags:** updated at the final pass's edge.
  - C = final `alu_cout`. Logic ops and MOVE therefore clear C, because the ALU returns cout=0 for them.
  - Z = 1 iff every byte written by the command is 0x00.
- **ALU drive outside EX states:** `alu_a`, `alu_b`, `alu_cin`, `alu_op` = 0.
- **Aliasing:** `rd==rs`, and wide pairs that overlap, are legal. Each pass reads the register-file contents as they stand at the start of that pass.
- **Busy:** `cmd_valid` while not in IDLE is not accepted. The command must be held until `cmd_ready`.

## Timing
- **Reset values:**
  - All registers 0x00; C=0, Z=0.
  - State IDLE, `cmd_ready=1`, `done_valid=0`, `done_y=0x00`, ALU drive outputs 0.
- **Latency**, with handshake at edge N:
  - EX0 during cycle N+1.
  - Narrow: DONE during cycle N+2.
  - Wide: EX1 during N+2, DONE during N+3.
  - `cmd_ready` returns to 1 one cycle after DONE.
  - Throughput: one command per 3 cycles (narrow) or 4 cycles (wide).
- **Visibility:** register, flag and `done_y` updates appear on `rd_data`/flags in the DONE cycle and remain stable afterward.
- **Reset mid-operation:** `rst_n` low in any state aborts immediately.
  - No `done_valid` for the aborted command; partial writes are discarded because all registers clear.
  - `cmd_ready=1` in the first cycle after release.

## Test plan
- **Narrow ADD:** load r0=0x14, r1=0x27; cmd op=101 rd=0 rs=1 usec=0 → `done_valid` at N+2, r0=0x3B, C=0, Z=0; r1 unchanged.
- **Wide ADD with carry chain:** pair0=0x00FF, pair2=0x0001; op=101 rd=0 rs=2 wide=1 → `alu_cin`=1 during EX1; r0=0x00, r1=0x01; C=0, Z=0; `done_valid` at N+3.
- **Wide SUB borrow:** pair0=0x0000, pair2=0x0001; op=110 wide=1 → r1:r0=0xFFFF, C=1, Z=0.
- **Wide RRC with usec:** C=1 and pair0=0x0001; op=011 rd=0 wide=1 usec=1.
  - EX0 operates on r1 (`alu_a`=0x00, cin=1).
  - Result: r1:r0=0x8000, C=1, Z=0.
- **Logic op clears carry, sets zero:** C=1, r0=0xA5, r1=0x5A; AND rd=0 rs=1 → r0=0x00, C=0, Z=1.
- **Busy and reset behaviour:**
  - `cmd_valid` and `load_en` held during a wide command → neither is taken until IDLE.
  - Pulling `rst_n` low during EX1 → no `done_valid`, all registers 0x00, C=Z=0, `cmd_ready=1` after release.
